// File: rtl/rename_dispatch_pkg.sv
// Shared constants, operand record and CDB-bypass resolve helper for the
// rename/dispatch slice. Tags run 1..ROB_DEPTH; tag 0 means value ready.
package rename_dispatch_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 5;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int COUNT_W   = $clog2(ROB_DEPTH + 1);

    localparam int PAY_OP_W  = 7;
    localparam int PAY_IMM_W = 25;
    localparam int PAY_PC_W  = 32;
    localparam int PAYLOAD_W = PAY_OP_W + PAY_IMM_W + PAY_PC_W;

    localparam logic [TAG_W-1:0] TAG_NONE  = '0;
    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);

    typedef struct packed {
        logic [TAG_W-1:0]  q;
        logic [DATA_W-1:0] v;
    } operand_t;

    // Unused operands read as ready zero; a live dependency that the CDB is
    // broadcasting this very cycle is captured so the packet starts ready.
    function automatic operand_t resolve_operand(
        input logic              use_op,
        input logic [TAG_W-1:0]  rf_q,
        input logic [DATA_W-1:0] rf_v,
        input logic              cdb_valid,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_data
    );
        operand_t r;
        r.q = rf_q;
        r.v = rf_v;
        if (!use_op) begin
            r.q = TAG_NONE;
            r.v = '0;
        end else if (rf_q != TAG_NONE && cdb_valid && cdb_tag == rf_q) begin
            r.q = TAG_NONE;
            r.v = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_dispatch_tag_allocator.sv
// ROB tag allocator: tail pointer wrapping 1..ROB_DEPTH plus occupancy count.
// Full depends only on registered count, so commit never feeds ready.
module rename_dispatch_tag_allocator
    import rename_dispatch_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rdy_i,
    input  logic             alloc_i,
    input  logic             commit_i,
    input  logic             flush_i,
    output logic [TAG_W-1:0] tail_o,
    output logic             full_o
);

    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               commit_ok;

    assign commit_ok = commit_i && (count_q != '0);

    always_comb begin
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            tail_d  = TAG_FIRST;
            count_d = '0;
        end else begin
            if (alloc_i) begin
                tail_d = (tail_q == TAG_W'(ROB_DEPTH)) ? TAG_FIRST : tail_q + TAG_W'(1);
            end
            if (alloc_i && !commit_ok) begin
                count_d = count_q + COUNT_W'(1);
            end else if (!alloc_i && commit_ok) begin
                count_d = count_q - COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tail_q  <= TAG_FIRST;
            count_q <= '0;
        end else if (rdy_i) begin
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Retiring from an empty ROB is a protocol error; the commit is dropped.
    a_commit_nonempty : assert property (@(posedge clk_i) disable iff (rst_i)
        !(rdy_i && !flush_i && commit_i && count_q == '0))
        else $error("rob_commit with empty ROB ignored");

    assign tail_o = tail_q;
    assign full_o = (count_q == COUNT_W'(ROB_DEPTH));

endmodule

// File: rtl/rename_dispatch.sv
// In-order dispatch: allocates a ROB tag, renames rd, resolves operands with a
// same-cycle CDB bypass and issues a registered packet to ROB plus RS or LSB.
module rename_dispatch
    import rename_dispatch_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rdy_i,

    input  logic                 inst_valid_i,
    output logic                 inst_ready_o,
    input  logic [REG_W-1:0]     inst_rd_i,
    input  logic [REG_W-1:0]     inst_rs1_i,
    input  logic [REG_W-1:0]     inst_rs2_i,
    input  logic                 inst_use_rs1_i,
    input  logic                 inst_use_rs2_i,
    input  logic                 inst_is_mem_i,
    input  logic [PAYLOAD_W-1:0] inst_payload_i,

    output logic                 rf_dispatch_enable_o,
    output logic [REG_W-1:0]     rf_dispatch_name_o,
    output logic [TAG_W-1:0]     rf_dispatch_rename_o,
    output logic [REG_W-1:0]     rf_dispatch_rs1_o,
    output logic [REG_W-1:0]     rf_dispatch_rs2_o,
    input  logic [TAG_W-1:0]     rf_Qi_i,
    input  logic [TAG_W-1:0]     rf_Qj_i,
    input  logic [DATA_W-1:0]    rf_Vi_i,
    input  logic [DATA_W-1:0]    rf_Vj_i,

    input  logic                 cdb_valid_i,
    input  logic [TAG_W-1:0]     cdb_tag_i,
    input  logic [DATA_W-1:0]    cdb_data_i,

    input  logic                 rob_commit_i,
    input  logic                 wrong_commit_i,
    input  logic                 rs_full_i,
    input  logic                 lsb_full_i,

    output logic                 out_rob_valid_o,
    output logic                 out_rs_valid_o,
    output logic                 out_lsb_valid_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic [REG_W-1:0]     out_rd_o,
    output logic [TAG_W-1:0]     out_Qi_o,
    output logic [TAG_W-1:0]     out_Qj_o,
    output logic [DATA_W-1:0]    out_Vi_o,
    output logic [DATA_W-1:0]    out_Vj_o,
    output logic [PAYLOAD_W-1:0] out_payload_o
);

    logic             rob_full, target_full, accept;
    logic [TAG_W-1:0] tail;
    operand_t         op_i, op_j;

    logic                 rob_valid_q, rs_valid_q, lsb_valid_q;
    logic [TAG_W-1:0]     tag_q, qi_q, qj_q;
    logic [REG_W-1:0]     rd_q;
    logic [DATA_W-1:0]    vi_q, vj_q;
    logic [PAYLOAD_W-1:0] payload_q;

    rename_dispatch_tag_allocator u_alloc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rdy_i    (rdy_i),
        .alloc_i  (accept),
        .commit_i (rob_commit_i),
        .flush_i  (wrong_commit_i),
        .tail_o   (tail),
        .full_o   (rob_full)
    );

    assign target_full  = inst_is_mem_i ? lsb_full_i : rs_full_i;
    assign inst_ready_o = rdy_i && !rst_i && !wrong_commit_i && !rob_full && !target_full;
    assign accept       = inst_valid_i && inst_ready_o;

    assign rf_dispatch_enable_o = accept;
    assign rf_dispatch_name_o   = inst_rd_i;
    assign rf_dispatch_rename_o = tail;
    assign rf_dispatch_rs1_o    = inst_rs1_i;
    assign rf_dispatch_rs2_o    = inst_rs2_i;

    assign op_i = resolve_operand(inst_use_rs1_i, rf_Qi_i, rf_Vi_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
    assign op_j = resolve_operand(inst_use_rs2_i, rf_Qj_i, rf_Vj_i, cdb_valid_i, cdb_tag_i, cdb_data_i);

    // Data registers only load on accept so a stalled packet keeps its contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rob_valid_q <= 1'b0;
            rs_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            tag_q       <= '0;
            rd_q        <= '0;
            qi_q        <= '0;
            qj_q        <= '0;
            vi_q        <= '0;
            vj_q        <= '0;
            payload_q   <= '0;
        end else if (rdy_i) begin
            if (accept) begin
                rob_valid_q <= 1'b1;
                rs_valid_q  <= !inst_is_mem_i;
                lsb_valid_q <= inst_is_mem_i;
                tag_q       <= tail;
                rd_q        <= inst_rd_i;
                qi_q        <= op_i.q;
                qj_q        <= op_j.q;
                vi_q        <= op_i.v;
                vj_q        <= op_j.v;
                payload_q   <= inst_payload_i;
            end else begin
                rob_valid_q <= 1'b0;
                rs_valid_q  <= 1'b0;
                lsb_valid_q <= 1'b0;
            end
        end
    end

    assign out_rob_valid_o = rob_valid_q;
    assign out_rs_valid_o  = rs_valid_q;
    assign out_lsb_valid_o = lsb_valid_q;
    assign out_tag_o       = tag_q;
    assign out_rd_o        = rd_q;
    assign out_Qi_o        = qi_q;
    assign out_Qj_o        = qj_q;
    assign out_Vi_o        = vi_q;
    assign out_Vj_o        = vj_q;
    assign out_payload_o   = payload_q;

endmodule
